// File: rtl/lsu_unit_pkg.sv
// Shared definitions for the load/store unit: access codes, FSM states and
// small helpers for decoding the access size.
package lsu_defs;

  localparam int XLEN = 32;

  // funct3 access codes; identical to the ram access encoding
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords need bit 0 clear, words need bits 1:0 clear
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of the assembled byte buffer for split loads.
module lsu_load_ext
  import lsu_defs::*;
(
  input  logic [XLEN-1:0] bytes_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  // Only halfword and word accesses are ever split, so B/BU never reach here
  always_comb begin
    data_o = bytes_i;
    case (funct3_i)
      F3_H:    data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
      F3_HU:   data_o = {16'b0, bytes_i[15:0]};
      default: data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one request, drives the data ram (splitting
// misaligned H/W accesses into byte accesses), assembles and extends load
// data, and returns a one-cycle response.
module lsu_unit
  import lsu_defs::*;
#(
  parameter int RD_LAT           = 1,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            ram_load,
  output logic            ram_store,
  output logic [2:0]      ram_access,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata
);

  state_e            state_q;
  logic [1:0]        k_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   lbuf_q;
  logic [2:0]        f3_q;
  logic              load_q;
  logic              split_q;

  logic              ram_load_q, ram_store_q;
  logic [2:0]        ram_access_q;
  logic [XLEN-1:0]   ram_addr_q, ram_wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;

  logic [XLEN-1:0]   addr_w;
  logic              mis_w;
  logic              acc_err_w;
  logic [1:0]        k_last_w;
  logic              last_w;
  logic [1:0]        k_nxt_w;
  logic [XLEN-1:0]   nxt_addr_w;
  logic [XLEN-1:0]   nxt_wdata_w;
  logic [XLEN-1:0]   lbuf_merged_w;
  logic [XLEN-1:0]   ext_data_w;
  logic [XLEN-1:0]   load_result_w;
  logic              go_wait_w;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign ram_load   = ram_load_q;
  assign ram_store  = ram_store_q;
  assign ram_access = ram_access_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

  // Effective address wraps mod 2^32; misalignment only matters for H/W
  assign addr_w    = req_base + req_offset;
  assign mis_w     = is_misaligned(req_funct3, addr_w[1:0]);
  assign acc_err_w = !f3_legal(req_funct3) || (req_load == req_store) ||
                     (mis_w && !ALLOW_MISALIGNED);

  // Byte sequencing for split accesses: halfwords end at k=1, words at k=3
  assign k_last_w    = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign last_w      = !split_q || (k_q == k_last_w);
  assign k_nxt_w     = k_q + 2'd1;
  assign nxt_addr_w  = addr_q + {30'b0, k_nxt_w};
  assign nxt_wdata_w = {24'b0, wdata_q[{k_nxt_w, 3'b000} +: 8]};

  // A load in ACCESS detours through WAIT when the ram has a registered read
  assign go_wait_w = (state_q == S_ACCESS) && load_q && (RD_LAT != 0);

  // Drop the byte returned this cycle into its little-endian slot
  always_comb begin
    lbuf_merged_w = lbuf_q;
    lbuf_merged_w[{k_q, 3'b000} +: 8] = ram_rdata[7:0];
  end

  lsu_load_ext u_ext (
    .bytes_i  (lbuf_merged_w),
    .funct3_i (f3_q),
    .data_o   (ext_data_w)
  );

  // Aligned loads already come back extended by the ram
  assign load_result_w = split_q ? ext_data_w : ram_rdata;

  // Request FSM with registered ram-side and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lbuf_q       <= '0;
      f3_q         <= 3'b000;
      load_q       <= 1'b0;
      split_q      <= 1'b0;
      ram_load_q   <= 1'b0;
      ram_store_q  <= 1'b0;
      ram_access_q <= 3'b000;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      ram_load_q  <= 1'b0;
      ram_store_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            load_q  <= req_load;
            wdata_q <= req_wdata;
            addr_q  <= addr_w;
            k_q     <= 2'd0;
            lbuf_q  <= '0;
            split_q <= mis_w;
            if (acc_err_w) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= S_ACCESS;
              ram_load_q  <= req_load;
              ram_store_q <= req_store;
              ram_addr_q  <= addr_w;
              if (mis_w) begin
                ram_access_q <= req_load ? F3_BU : F3_B;
                ram_wdata_q  <= {24'b0, req_wdata[7:0]};
              end else begin
                ram_access_q <= req_funct3;
                ram_wdata_q  <= req_wdata;
              end
            end
          end
        end
        S_ACCESS, S_WAIT: begin
          if (go_wait_w) begin
            state_q <= S_WAIT;
          end else begin
            if (load_q) begin
              lbuf_q <= lbuf_merged_w;
            end
            if (last_w) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= load_q ? load_result_w : '0;
            end else begin
              state_q      <= S_ACCESS;
              k_q          <= k_nxt_w;
              ram_load_q   <= load_q;
              ram_store_q  <= !load_q;
              ram_access_q <= load_q ? F3_BU : F3_B;
              ram_addr_q   <= nxt_addr_w;
              ram_wdata_q  <= nxt_wdata_w;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: two instances (registered-read ram with misaligned
// splitting, and combinational-read ram with misaligned reported as error),
// each attached to a byte-array ram model, checked against a byte-level
// memory image and the access rules.
module tb_lsu_unit;

  typedef struct packed {
    logic        st;
    logic [2:0]  acc;
    logic [31:0] addr;
    logic [31:0] wd;
  } strobe_t;

  logic clk = 1'b0;
  logic rst;
  logic clr_mem;

  logic        a_req_valid, a_req_ready, a_req_load, a_req_store;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_base, a_req_offset, a_req_wdata;
  logic        a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        a_ram_load, a_ram_store;
  logic [2:0]  a_ram_access;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

  logic        b_req_valid, b_req_ready, b_req_load, b_req_store;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_base, b_req_offset, b_req_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic        b_ram_load, b_ram_store;
  logic [2:0]  b_ram_access;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

  logic [7:0] mem     [2][256];
  logic [7:0] ref_mem [2][256];

  strobe_t sqa[$];
  strobe_t sqb[$];

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  lsu_unit #(.RD_LAT(1), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_load(a_req_load), .req_store(a_req_store), .req_funct3(a_req_funct3),
    .req_base(a_req_base), .req_offset(a_req_offset), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
    .ram_load(a_ram_load), .ram_store(a_ram_store), .ram_access(a_ram_access),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  lsu_unit #(.RD_LAT(0), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_load(b_req_load), .req_store(b_req_store), .req_funct3(b_req_funct3),
    .req_base(b_req_base), .req_offset(b_req_offset), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .ram_load(b_ram_load), .ram_store(b_ram_store), .ram_access(b_ram_access),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  function automatic int acc_bytes(input logic [2:0] acc);
    return (acc[1:0] == 2'b00) ? 1 : (acc[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Ram read: little-endian bytes, extended per access code
  function automatic logic [31:0] ram_rd(input int m, input logic [2:0] acc,
                                          input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < acc_bytes(acc); k++) v[8*k +: 8] = mem[m][a[7:0] + 8'(k)];
    if (acc == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (acc == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Ram model: writes at the clock edge; instance A reads with one cycle latency
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] <= 8'h00;
        mem[1][i] <= 8'h00;
      end
    end else begin
      if (a_ram_store)
        for (int k = 0; k < acc_bytes(a_ram_access); k++)
          mem[0][a_ram_addr[7:0] + 8'(k)] <= a_ram_wdata[8*k +: 8];
      if (b_ram_store)
        for (int k = 0; k < acc_bytes(b_ram_access); k++)
          mem[1][b_ram_addr[7:0] + 8'(k)] <= b_ram_wdata[8*k +: 8];
      if (a_ram_load) a_ram_rdata <= ram_rd(0, a_ram_access, a_ram_addr);
    end
  end

  assign b_ram_rdata = ram_rd(1, b_ram_access, b_ram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every ram strobe cycle; the two strobes must never coincide
  always @(negedge clk) begin
    if (a_ram_load || a_ram_store) begin
      sqa.push_back('{st: a_ram_store, acc: a_ram_access, addr: a_ram_addr, wd: a_ram_wdata});
      chk("a_load_and_store", {31'b0, a_ram_load && a_ram_store}, 32'd0);
    end
    if (b_ram_load || b_ram_store) begin
      sqb.push_back('{st: b_ram_store, acc: b_ram_access, addr: b_ram_addr, wd: b_ram_wdata});
      chk("b_load_and_store", {31'b0, b_ram_load && b_ram_store}, 32'd0);
    end
  end

  // Reference load result from the memory image
  function automatic logic [31:0] ref_load(input bit w, input logic [2:0] f3,
                                            input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ab;
    int nb;
    nb = acc_bytes(f3);
    v  = 0;
    for (int k = 0; k < nb; k++) begin
      ab = a + k;
      v  = v + (32'(ref_mem[w][ab[7:0]]) << (8 * k));
    end
    if (f3 == 3'b000 && v >= 32'h80)   v = v - 32'h100;
    if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  function automatic logic [31:0] outp(input bit w, input int sel);
    case (sel)
      0:       return {31'b0, w ? b_req_ready : a_req_ready};
      1:       return {31'b0, w ? b_rsp_valid : a_rsp_valid};
      2:       return {31'b0, w ? b_rsp_err   : a_rsp_err};
      default: return w ? b_rsp_rdata : a_rsp_rdata;
    endcase
  endfunction

  task automatic drive(input bit w, input bit v, input bit ld, input bit st,
                       input logic [2:0] f3, input logic [31:0] base, off, wd);
    if (w) begin
      b_req_valid = v; b_req_load = ld; b_req_store = st; b_req_funct3 = f3;
      b_req_base = base; b_req_offset = off; b_req_wdata = wd;
    end else begin
      a_req_valid = v; a_req_load = ld; a_req_store = st; a_req_funct3 = f3;
      a_req_base = base; a_req_offset = off; a_req_wdata = wd;
    end
  endtask

  // One complete request on instance w, checked against the access rules
  task automatic run_req(input bit w, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] base, off, wd,
                         output logic [31:0] obs_rd, output int obs_lat);
    logic [31:0] addr, ab, exp_rd;
    bit legal, mis, err, split;
    int nb, rdl, exp_lat, exp_n, c;
    strobe_t q[$];
    addr  = base + off;
    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
            (f3 == 3'b100) || (f3 == 3'b101);
    nb    = acc_bytes(f3);
    mis   = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    rdl   = w ? 0 : 1;
    err   = !legal || (ld == st) || (mis && w);
    split = mis && !err;
    exp_lat = err ? 1 : !split ? (st ? 2 : 2 + rdl) : (st ? nb + 1 : nb * (1 + rdl) + 1);
    exp_n   = err ? 0 : split ? nb : 1;
    exp_rd  = (err || st) ? 32'h0 : ref_load(w, f3, addr);

    if (w) sqb.delete(); else sqa.delete();
    chk("ready_idle", outp(w, 0), 1);
    drive(w, 1'b1, ld, st, f3, base, off, wd);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("ready_busy", outp(w, 0), 0);
    c = 1;
    while (outp(w, 1) != 1 && c < 64) begin
      @(posedge clk); #1;
      c++;
    end
    obs_rd  = outp(w, 3);
    obs_lat = c;
    chk("rsp_valid", outp(w, 1), 1);
    chk("latency", c, exp_lat);
    chk("rsp_err", outp(w, 2), {31'b0, err});
    chk("rsp_rdata", obs_rd, exp_rd);
    @(posedge clk); #1;
    chk("rsp_valid_drop", outp(w, 1), 0);
    chk("ready_after", outp(w, 0), 1);

    q = w ? sqb : sqa;
    chk("strobe_count", q.size(), exp_n);
    for (int i = 0; i < q.size() && i < exp_n; i++) begin
      ab = addr + (split ? i : 0);
      chk("strobe_addr", q[i].addr, ab);
      chk("strobe_access", {29'b0, q[i].acc}, {29'b0, split ? (ld ? 3'b100 : 3'b000) : f3});
      chk("strobe_dir", {31'b0, q[i].st}, {31'b0, st});
      if (st) chk("strobe_wdata", q[i].wd, split ? ((wd >> (8 * i)) & 32'hFF) : wd);
    end

    if (!err && st)
      for (int k = 0; k < nb; k++) begin
        ab = addr + k;
        ref_mem[w][ab[7:0]] = wd[8*k +: 8];
      end
  endtask

  logic [31:0] rd;
  int lat;
  logic [2:0] tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst = 1'b0;
    clr_mem = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 256; i++) ref_mem[m][i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, a_req_ready}, 1);
    chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 0);
    chk("rst_rsp_err", {31'b0, a_rsp_err}, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_ram_strobes", {30'b0, a_ram_load, a_ram_store}, 0);
    chk("rst_ram_access", {29'b0, a_ram_access}, 0);
    chk("rst_ram_addr", a_ram_addr, 0);
    chk("rst_ram_wdata", a_ram_wdata, 0);
    chk("rst_b_ready", {31'b0, b_req_ready}, 1);
    rst = 1'b1;
    clr_mem = 1'b0;
    @(posedge clk); #1;

    // Fill and aligned/narrow loads
    run_req(0, 0, 1, 3'b010, 32'h0, 32'h0, 32'h00112233, rd, lat);
    chk("SW0_lat", lat, 2);
    run_req(0, 0, 1, 3'b010, 32'h0, 32'h4, 32'hAABBCCDD, rd, lat);
    run_req(0, 1, 0, 3'b000, 32'h0, 32'h7, 32'h0, rd, lat);
    chk("LB7", rd, 32'hFFFFFFAA);
    chk("LB7_lat", lat, 3);
    run_req(0, 1, 0, 3'b100, 32'h0, 32'h7, 32'h0, rd, lat);
    chk("LBU7", rd, 32'h000000AA);
    run_req(0, 1, 0, 3'b001, 32'h0, 32'h6, 32'h0, rd, lat);
    chk("LH6", rd, 32'hFFFFAABB);
    run_req(0, 1, 0, 3'b101, 32'h0, 32'h2, 32'h0, rd, lat);
    chk("LHU2", rd, 32'h00000011);
    run_req(0, 1, 0, 3'b010, 32'h0, 32'h4, 32'h0, rd, lat);
    chk("LW4", rd, 32'hAABBCCDD);

    // Split load and split store
    run_req(0, 1, 0, 3'b010, 32'h1, 32'h2, 32'h0, rd, lat);
    chk("LW3_split", rd, 32'hBBCCDD00);
    chk("LW3_lat", lat, 9);
    run_req(0, 0, 1, 3'b001, 32'h0, 32'h5, 32'h0000BEEF, rd, lat);
    chk("SH5_lat", lat, 3);
    run_req(0, 1, 0, 3'b010, 32'h0, 32'h4, 32'h0, rd, lat);
    chk("LW4_after_SH", rd, 32'hAABEEFDD);
    run_req(0, 1, 0, 3'b001, 32'h0, 32'h5, 32'h0, rd, lat);
    chk("LH5_split", rd, 32'hFFFFBEEF);

    // Errors
    run_req(0, 1, 0, 3'b011, 32'h0, 32'h0, 32'h0, rd, lat);
    chk("err_f3_011_lat", lat, 1);
    run_req(0, 1, 1, 3'b010, 32'h0, 32'h0, 32'h0, rd, lat);
    run_req(1, 1, 0, 3'b001, 32'h0, 32'h1, 32'h0, rd, lat);
    chk("err_LH1_noallow", rd, 32'h0);

    // Address wrap across 2^32
    run_req(0, 0, 1, 3'b010, 32'hFFFFFFFE, 32'h1, 32'h5A6B7C8D, rd, lat);
    run_req(0, 1, 0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, rd, lat);
    chk("LW_wrap", rd, 32'h5A6B7C8D);

    // Reset in the middle of a split store
    run_req(0, 0, 1, 3'b010, 32'h0, 32'h0, 32'h0, rd, lat);
    run_req(0, 0, 1, 3'b010, 32'h0, 32'h4, 32'h0, rd, lat);
    sqa.delete();
    drive(0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h1, 32'h0, 32'h11223344);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_ready", {31'b0, a_req_ready}, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (a_rsp_valid) seen++;
        @(posedge clk); #1;
      end
      chk("midrst_no_rsp", seen, 0);
    end
    chk("midrst_strobes", sqa.size(), 2);
    ref_mem[0][1] = 8'h44;
    ref_mem[0][2] = 8'h33;
    run_req(0, 1, 0, 3'b010, 32'h0, 32'h0, 32'h0, rd, lat);
    chk("midrst_LW0", rd, 32'h00334400);

    // Combinational-read instance
    run_req(1, 0, 1, 3'b010, 32'h0, 32'h8, 32'hCAFEF00D, rd, lat);
    run_req(1, 1, 0, 3'b010, 32'h0, 32'h8, 32'h0, rd, lat);
    chk("B_LW8", rd, 32'hCAFEF00D);
    chk("B_LW8_lat", lat, 2);
    run_req(1, 1, 0, 3'b000, 32'h4, 32'h5, 32'h0, rd, lat);
    chk("B_LB9", rd, 32'hFFFFFFF0);

    // Randomized requests on both instances
    for (int i = 0; i < 60; i++) begin
      bit w, ld, st;
      int r;
      logic [2:0] f3;
      w  = (i % 3 == 2);
      f3 = ($urandom_range(0, 7) != 0) ? tab[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 11);
      ld = (r < 5) || (r == 10);
      st = (r >= 5 && r < 10) || (r == 10);
      run_req(w, ld, st, f3, $urandom, $urandom, $urandom, rd, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit sitting directly upstream of the data `ram`; the only block that drives its load/store/access/addr/data_in pins.
- Accepts one memory request at a time from the execute stage and computes the effective address.
- Issues the request to the ram. Misaligned halfword/word accesses are split into byte accesses.
- Assembles load data, sign- or zero-extends it, and returns a single-cycle response to writeback.

Parameters:
- RD_LAT, 1, ram read latency in cycles from the ram_load cycle to a valid ram_rdata; legal values 0 and 1.
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = report misaligned access as an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_funct3  in  3  access code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  illegal or misaligned request; qualified by rsp_valid
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- ram_load  out  1  to ram load
- ram_store  out  1  to ram store
- ram_access  out  3  to ram access
- ram_addr  out  32  to ram addr
- ram_wdata  out  32  to ram data_in
- ram_rdata  in  32  from ram data_out, already extended per ram_access

Behaviour:
- Reset (rst==0 at a clk edge):
  - State becomes IDLE.
  - req_ready=1.
  - rsp_valid, rsp_err, ram_load, ram_store = 0.
  - ram_access, ram_addr, ram_wdata, rsp_rdata = 0.
  - All ram-side outputs are registered.
- Address: addr = req_base + req_offset mod 2^32. The split byte address addr+k also wraps mod 2^32.
- Handshake:
  - A request is accepted at an edge where req_valid && req_ready.
  - req_ready=1 only in IDLE. It drops the cycle after acceptance and returns in the cycle after rsp_valid.
  - There is no response backpressure.
- Error check at acceptance:
  - Errors: funct3 in {011,110,111}; req_load==req_store; or misaligned with ALLOW_MISALIGNED=0.
  - Misaligned means H/HU with addr[0]!=0, or W with addr[1:0]!=0.
  - On error there is no ram strobe. The state goes to RESP, giving rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after acceptance.
- States: IDLE, ACCESS, WAIT, RESP.
- Aligned access:
  - ACCESS holds ram_load or ram_store=1, ram_access=funct3, ram_addr=addr, ram_wdata=req_wdata for exactly one cycle.
- Split access:
  - nbytes = 2 (H/HU) or 4 (W). Byte counter k runs 0..nbytes-1.
  - Each byte is its own ACCESS cycle with ram_access=100 (loads) or 000 (stores) and ram_addr=addr+k.
  - Store data for byte k: ram_wdata={24'b0, req_wdata[8k+7:8k]}.
  - Load byte k is placed at buf[8k+7:8k] (little-endian).
- Load data capture:
  - RD_LAT=1: ACCESS -> WAIT (ram strobes 0), and ram_rdata is captured at the end of WAIT.
  - RD_LAT=0: ram_rdata is captured at the end of ACCESS, and WAIT is skipped.
- Stores never use WAIT.
- Transitions:
  - After the last byte/access, go to RESP; otherwise go back to ACCESS with k+1.
  - RESP lasts one cycle (rsp_valid=1), then IDLE.
- Latency, acceptance edge to rsp_valid cycle:
  - Aligned store: 2 cycles.
  - Aligned load: 2+RD_LAT cycles.
  - Split: nbytes×(1+RD_LAT)+1 cycles for loads, nbytes+1 cycles for stores.
- Extension:
  - Aligned: rsp_rdata = ram_rdata as returned.
  - Split: rsp_rdata = buf, with H sign-extended from bit 15 and HU zero-extended.
- Reset mid-operation: the state is abandoned with no response. Bytes already stored stay written; the remaining bytes are not written.
- ram_store and ram_load are never both 1. Outside ACCESS both are 0.

Decomposition:
- Shared package lsu_defs:
  - funct3 constants F3_B/H/W/BU/HU, matching the ram access encoding.
  - State encodings S_IDLE/S_ACCESS/S_WAIT/S_RESP.
  - Width constants.
- One sub-module, lsu_load_ext: combinational byte-buffer sign/zero extension for split loads, selected by funct3.

Test Plan:
- SW 0x00112233 @0 and SW 0xAABBCCDD @4 (base=0, offsets 0/4) -> one ram_store cycle each, access=010. rsp_valid 2 cycles after acceptance, rsp_err=0.
- After the fill:
  - LB @7 -> 0xFFFFFFAA.
  - LBU @7 -> 0x000000AA.
  - LH @6 -> 0xFFFFAABB.
  - LHU @2 -> 0x00000011.
  - LW @4 -> 0xAABBCCDD.
  - Each takes 3 cycles with RD_LAT=1.
- Misaligned LW base=1, offset=2 (addr 3) -> four ram_load cycles at addr 3,4,5,6 with access=100. rsp_rdata=0xBBCCDD00 after 9 cycles.
- Misaligned SH 0xBEEF @5 -> byte stores 0xEF@5, 0xBE@6. A subsequent LW @4 returns 0xAABEEFDD.
- Errors, each giving rsp_err=1, rsp_rdata=0 the next cycle with no ram strobe:
  - funct3=011.
  - req_load=req_store=1.
  - LH @1 with ALLOW_MISALIGNED=0.
- Reset mid-split:
  - Start a misaligned SW 0x11223344 @1 over 0x00000000 @0..7 and drop rst after the 2nd byte store.
  - Expect no rsp_valid and req_ready=1 after release.
  - A subsequent LW @0 returns 0x00334400.
